// File: rtl/keypad_if.sv
// Raw push-button levels in, conditioned key events out, between the
// panel and the voting-machine core FSM.
interface keypad_if;
  logic [9:0] key_digit;
  logic       key_confirm;
  logic       key_start;
  logic       key_finish;
  logic       key_swap;
  logic [3:0] digit;
  logic       valid;
  logic       start;
  logic       finish;
  logic       swap;
  logic       key_active;

  modport master (
    output key_digit, key_confirm, key_start, key_finish, key_swap,
    input  digit, valid, start, finish, swap, key_active
  );

  modport slave (
    input  key_digit, key_confirm, key_start, key_finish, key_swap,
    output digit, valid, start, finish, swap, key_active
  );
endinterface

// File: rtl/keypad_frontend.sv
// Synchronises and debounces the 14 panel buttons and turns each accepted
// press into the registered pulses/levels the core FSM samples.
module keypad_frontend #(
  parameter int DEBOUNCE = 4
) (
  input  logic     clock,
  input  logic     reset,
  keypad_if.slave  kp
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_RELEASE  = 2'd2
  } state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE - 2);
  localparam logic [7:0] REL_LAST = 8'(DEBOUNCE - 2);

  function automatic logic is_single(input logic [13:0] v);
    return (v != 14'd0) && ((v & (v - 14'd1)) == 14'd0);
  endfunction

  function automatic logic [3:0] encode(input logic [13:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 14; i++) begin
      c = v[i] ? 4'(i) : c;
    end
    return c;
  endfunction

  logic [13:0] raw_s;
  logic [13:0] sync1_r, sync2_r;
  logic        single_s, none_s;
  logic [3:0]  s_code_s;

  state_t      state_r, state_nxt_s;
  logic [3:0]  code_r, code_nxt_s;
  logic [7:0]  deb_cnt_r, deb_cnt_nxt_s;
  logic [7:0]  rel_cnt_r, rel_cnt_nxt_s;
  logic [3:0]  digit_r, digit_nxt_s;
  logic        valid_r, valid_nxt_s;
  logic        start_r, start_nxt_s;
  logic        finish_r, finish_nxt_s;
  logic        swap_r, swap_nxt_s;
  logic        active_r, active_nxt_s;

  assign raw_s    = {kp.key_swap, kp.key_finish, kp.key_start, kp.key_confirm, kp.key_digit};
  assign single_s = is_single(sync2_r);
  assign none_s   = (sync2_r == 14'd0);
  assign s_code_s = encode(sync2_r);

  // Two-flop synchroniser for the asynchronous button levels
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r <= 14'd0;
      sync2_r <= 14'd0;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Next-state, counter and emit decode
  always_comb begin
    state_nxt_s   = state_r;
    code_nxt_s    = code_r;
    deb_cnt_nxt_s = deb_cnt_r;
    rel_cnt_nxt_s = rel_cnt_r;
    digit_nxt_s   = digit_r;
    valid_nxt_s   = 1'b0;
    start_nxt_s   = 1'b0;
    finish_nxt_s  = 1'b0;
    swap_nxt_s    = swap_r;
    case (state_r)
      ST_IDLE: begin
        if (single_s) begin
          code_nxt_s    = s_code_s;
          deb_cnt_nxt_s = 8'd0;
          state_nxt_s   = ST_DEBOUNCE;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_DEBOUNCE: begin
        if (!single_s || (s_code_s != code_r)) begin
          state_nxt_s = ST_IDLE;
        end else if (deb_cnt_r == DEB_LAST) begin
          state_nxt_s   = ST_RELEASE;
          rel_cnt_nxt_s = 8'd0;
          // Codes 0..9 are digits; 14/15 never latch since only 14 keys exist
          case (code_r)
            4'd10: valid_nxt_s = 1'b1;
            4'd11: begin
              valid_nxt_s = 1'b1;
              start_nxt_s = 1'b1;
            end
            4'd12: finish_nxt_s = 1'b1;
            4'd13: swap_nxt_s   = ~swap_r;
            default: begin
              digit_nxt_s = code_r;
              valid_nxt_s = 1'b1;
            end
          endcase
        end else begin
          deb_cnt_nxt_s = deb_cnt_r + 8'd1;
        end
      end
      ST_RELEASE: begin
        if (!none_s) begin
          rel_cnt_nxt_s = 8'd0;
        end else if (rel_cnt_r == REL_LAST) begin
          state_nxt_s   = ST_IDLE;
        end else begin
          rel_cnt_nxt_s = rel_cnt_r + 8'd1;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
    active_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      code_r    <= 4'd0;
      deb_cnt_r <= 8'd0;
      rel_cnt_r <= 8'd0;
      digit_r   <= 4'd0;
      valid_r   <= 1'b0;
      start_r   <= 1'b0;
      finish_r  <= 1'b0;
      swap_r    <= 1'b0;
      active_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      code_r    <= code_nxt_s;
      deb_cnt_r <= deb_cnt_nxt_s;
      rel_cnt_r <= rel_cnt_nxt_s;
      digit_r   <= digit_nxt_s;
      valid_r   <= valid_nxt_s;
      start_r   <= start_nxt_s;
      finish_r  <= finish_nxt_s;
      swap_r    <= swap_nxt_s;
      active_r  <= active_nxt_s;
    end
  end

  assign kp.digit      = digit_r;
  assign kp.valid      = valid_r;
  assign kp.start      = start_r;
  assign kp.finish     = finish_r;
  assign kp.swap       = swap_r;
  assign kp.key_active = active_r;

endmodule
